// File: rtl/mem_burst_responder.sv
// mem_burst_responder
//   Memory-side responder shared by the I-cache and D-cache fill FSMs.
//   Owns a single-ported word store. D-side writes complete in one IDLE
//   cycle and are acknowledged the cycle after. Block fills read one word
//   per cycle from the block base and return each word LATENCY cycles later,
//   in order, on the port that won arbitration. D-side wins over I-side.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   i_req / i_addr    I-side fill request and byte address (any byte in block)
//   i_busy            I-side burst in progress
//   i_valid / i_data  I-side word beat (data is 0 when not valid)
//   d_req / d_wr      D-side request; d_wr=1 write, d_wr=0 block fill
//   d_addr / d_wdata  D-side byte address and write data
//   d_busy            D-side fill burst in progress (writes never set it)
//   d_valid / d_data  D-side word beat or write ack (data is 0 on ack)
module mem_burst_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 4,
  parameter int BURST   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_busy,
  output logic [DATA_W-1:0] i_data,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_busy,
  output logic [DATA_W-1:0] d_data,
  output logic              d_valid
);

  localparam int KW        = $clog2(BURST);      // word-in-block index width
  localparam int BLK_LG    = KW + 1;             // byte offset bits in a block
  localparam int BLK_W     = ADDR_W - BLK_LG;    // block number width
  localparam int MEM_WORDS = 2 ** (ADDR_W - 1);

  // Pipeline holds only the final beat: the burst has fully retired on the
  // edge that shifts it out.
  localparam logic [LATENCY-1:0] LAST_ONLY = LATENCY'(1) << (LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic              own_d;
    logic [DATA_W-1:0] data;
  } beat_t;

  state_t                   state;
  logic                     own_d;
  logic [BLK_W-1:0]         blk;
  logic [KW-1:0]            k;
  logic                     wr_ack;
  logic [LATENCY-1:0]       vld_pipe;
  beat_t [LATENCY-1:0]      beat_pipe;
  logic [DATA_W-1:0]        mem [MEM_WORDS];
  logic [ADDR_W-2:0]        rd_idx;
  logic                     wr_en;
  logic                     out_vld;
  beat_t                    out_beat;
  logic                     d_beat;
  logic                     unused_addr_bits;

  // Block-aligned base plus k never leaves the block: just concatenate.
  assign rd_idx = {blk, k};
  assign wr_en  = ~rst & (state == IDLE) & d_req & d_wr;

  // Offset bits select nothing: fills always start at the block base.
  assign unused_addr_bits = ^{i_addr[BLK_LG-1:0], d_addr[0]};

  // Word store: not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[d_addr[ADDR_W-1:1]] <= d_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      own_d     <= 1'b0;
      blk       <= '0;
      k         <= '0;
      i_busy    <= 1'b0;
      d_busy    <= 1'b0;
      wr_ack    <= 1'b0;
      vld_pipe  <= '0;
      beat_pipe <= '0;
    end else begin
      wr_ack <= 1'b0;

      // Latency pipeline; stage 0 captures the word read this cycle.
      vld_pipe[0]  <= (state == ISSUE);
      beat_pipe[0] <= (state == ISSUE) ? beat_t'{own_d, mem[rd_idx]} : '0;
      for (int s = LATENCY - 1; s > 0; s--) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        beat_pipe[s] <= beat_pipe[s-1];
      end

      case (state)
        IDLE: begin
          if (d_req && d_wr) begin
            wr_ack <= 1'b1;
          end else if (d_req) begin
            own_d  <= 1'b1;
            blk    <= d_addr[ADDR_W-1:BLK_LG];
            k      <= '0;
            d_busy <= 1'b1;
            state  <= ISSUE;
          end else if (i_req) begin
            own_d  <= 1'b0;
            blk    <= i_addr[ADDR_W-1:BLK_LG];
            k      <= '0;
            i_busy <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          k <= k + 1'b1;
          if (k == KW'(BURST - 1)) state <= DRAIN;
        end
        DRAIN: begin
          if (vld_pipe == LAST_ONLY) begin
            state  <= IDLE;
            i_busy <= 1'b0;
            d_busy <= 1'b0;
            k      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_vld  = vld_pipe[LATENCY-1];
  assign out_beat = beat_pipe[LATENCY-1];

  // Beats steer to the owner only; the idle port stays at 0.
  assign i_valid = out_vld & ~out_beat.own_d;
  assign i_data  = i_valid ? out_beat.data : '0;
  assign d_beat  = out_vld & out_beat.own_d;
  assign d_valid = wr_ack | d_beat;
  assign d_data  = d_beat ? out_beat.data : '0;

endmodule

// File: tb/tb_mem_burst_responder.sv
module tb_mem_burst_responder;

  typedef logic [35:0] ov_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_busy, i_valid, d_busy, d_valid;
  logic [15:0] i_data, d_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_burst_responder #(.ADDR_W(16), .DATA_W(16), .LATENCY(4), .BURST(8)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_busy(i_busy), .i_data(i_data), .i_valid(i_valid),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_busy(d_busy), .d_data(d_data), .d_valid(d_valid)
  );

  function automatic ov_t outs();
    return {i_busy, i_valid, i_data, d_busy, d_valid, d_data};
  endfunction

  function automatic ov_t mk(input logic ib, input logic iv, input logic [15:0] id,
                             input logic db, input logic dv, input logic [15:0] dd);
    return {ib, iv, id, db, dv, dd};
  endfunction

  // One write per cycle; starts and ends just after a falling edge.
  task automatic mem_write(input logic [15:0] a, input logic [15:0] w);
    d_req = 1'b1; d_wr = 1'b1; d_addr = a; d_wdata = w;
    @(negedge clk);
    d_req = 1'b0; d_wr = 1'b0;
  endtask

  task automatic preload();
    for (int k = 0; k < 8; k++) begin
      mem_write(16'(32'h0040 + 2*k), 16'(32'hA000 + k));
      mem_write(16'(32'h0100 + 2*k), 16'(32'hB000 + k));
      mem_write(16'(32'h0200 + 2*k), 16'(32'hD000 + k));
      mem_write(16'(32'hFFF0 + 2*k), 16'(32'hC000 + k));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    ov_t got, exp;
    rst = 1'b1;
    @(negedge clk);
    got = outs(); exp = '0; checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_por got %h exp %h", got, exp); end
    rst = 1'b0;
    mem_write(16'h0300, 16'hEEEE);
    got = outs(); exp = mk(0, 0, 0, 0, 1, 0); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_pre_ack got %h exp %h", got, exp); end
    rst = 1'b1;
    #1;
    got = outs(); exp = '0; checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_idle_async got %h exp %h", got, exp); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      got = outs(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_idle_after c=%0d got %h exp %h", c, got, exp); end
    end
  endtask

  task automatic test_i_fill();
    ov_t got, exp;
    logic bt;
    i_req = 1'b1; i_addr = 16'h004B;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      bt  = (c >= 4 && c <= 11);
      exp = mk(c <= 11, bt, bt ? 16'(32'hA000 + c - 4) : 16'h0, 0, 0, 0);
      got = outs(); checks++;
      if (got !== exp) begin errors++; $display("FAIL i_fill c=%0d got %h exp %h", c, got, exp); end
      if (c == 0) i_req = 1'b0;
    end
  endtask

  task automatic test_priority();
    ov_t got, exp;
    logic dbt, ibt;
    i_req = 1'b1; i_addr = 16'h0040;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0100;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      dbt = (c >= 4 && c <= 11);
      ibt = (c >= 17 && c <= 24);
      exp = mk(c >= 13 && c <= 24, ibt, ibt ? 16'(32'hA000 + c - 17) : 16'h0,
               c <= 11, dbt, dbt ? 16'(32'hB000 + c - 4) : 16'h0);
      got = outs(); checks++;
      if (got !== exp) begin errors++; $display("FAIL priority c=%0d got %h exp %h", c, got, exp); end
      if (c == 0) d_req = 1'b0;
      if (i_busy) i_req = 1'b0;
    end
    i_req = 1'b0;
  endtask

  task automatic test_write_then_read();
    ov_t got, exp;
    logic bt;
    logic [15:0] w;
    mem_write(16'h0206, 16'h1234);
    got = outs(); exp = mk(0, 0, 0, 0, 1, 0); checks++;
    if (got !== exp) begin errors++; $display("FAIL wr_ack got %h exp %h", got, exp); end
    @(negedge clk);
    got = outs(); exp = '0; checks++;
    if (got !== exp) begin errors++; $display("FAIL wr_ack_pulse got %h exp %h", got, exp); end
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      bt  = (c >= 4 && c <= 11);
      w   = (c == 7) ? 16'h1234 : 16'(32'hD000 + c - 4);
      exp = mk(0, 0, 0, c <= 11, bt, bt ? w : 16'h0);
      got = outs(); checks++;
      if (got !== exp) begin errors++; $display("FAIL wr_read c=%0d got %h exp %h", c, got, exp); end
      if (c == 0) d_req = 1'b0;
    end
  endtask

  task automatic test_top_of_space();
    ov_t got, exp;
    logic bt;
    i_req = 1'b1; i_addr = 16'hFFF7;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      bt  = (c >= 4 && c <= 11);
      exp = mk(c <= 11, bt, bt ? 16'(32'hC000 + c - 4) : 16'h0, 0, 0, 0);
      got = outs(); checks++;
      if (got !== exp) begin errors++; $display("FAIL top_space c=%0d got %h exp %h", c, got, exp); end
      if (c == 0) i_req = 1'b0;
    end
  endtask

  task automatic test_blocked_write();
    ov_t got, exp;
    logic bt;
    logic [15:0] w;
    i_req = 1'b1; i_addr = 16'h0040;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bt  = (c >= 4 && c <= 11);
      exp = mk(c <= 11, bt, bt ? 16'(32'hA000 + c - 4) : 16'h0, 0, c == 13, 0);
      got = outs(); checks++;
      if (got !== exp) begin errors++; $display("FAIL blocked_wr c=%0d got %h exp %h", c, got, exp); end
      if (c == 0) i_req = 1'b0;
      if (c == 2) begin d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0042; d_wdata = 16'h5555; end
      if (d_valid) begin d_req = 1'b0; d_wr = 1'b0; end
    end
    d_req = 1'b0; d_wr = 1'b0;
    // The held write must now be in the store.
    i_req = 1'b1; i_addr = 16'h0041;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      bt  = (c >= 4 && c <= 11);
      w   = (c == 5) ? 16'h5555 : 16'(32'hA000 + c - 4);
      exp = mk(c <= 11, bt, bt ? w : 16'h0, 0, 0, 0);
      got = outs(); checks++;
      if (got !== exp) begin errors++; $display("FAIL blocked_wr_read c=%0d got %h exp %h", c, got, exp); end
      if (c == 0) i_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_burst();
    ov_t got, exp;
    logic bt;
    i_req = 1'b1; i_addr = 16'h0100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      bt  = (c >= 4);
      exp = mk(1, bt, bt ? 16'(32'hB000 + c - 4) : 16'h0, 0, 0, 0);
      got = outs(); checks++;
      if (got !== exp) begin errors++; $display("FAIL pre_rst c=%0d got %h exp %h", c, got, exp); end
      if (c == 0) i_req = 1'b0;
    end
    rst = 1'b1;
    #1;
    got = outs(); exp = '0; checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_burst_async got %h exp %h", got, exp); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      got = outs(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_burst_after c=%0d got %h exp %h", c, got, exp); end
    end
    i_req = 1'b1; i_addr = 16'h010E;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      bt  = (c >= 4 && c <= 11);
      exp = mk(c <= 11, bt, bt ? 16'(32'hB000 + c - 4) : 16'h0, 0, 0, 0);
      got = outs(); checks++;
      if (got !== exp) begin errors++; $display("FAIL post_rst_fill c=%0d got %h exp %h", c, got, exp); end
      if (c == 0) i_req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
    test_reset();
    preload();
    test_i_fill();
    test_priority();
    test_write_then_read();
    test_top_of_space();
    test_blocked_write();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
